// File: rtl/morse_key_receiver.sv
// Straight-key Morse receiver: times key-down/key-up intervals and packs
// dots/dashes into a code/length pair with a one-cycle valid or error strobe.
module morse_key_receiver #(
    parameter int CLK_PER_MS   = 1000,
    parameter int MIN_PRESS_MS = 20,
    parameter int DOT_MAX_MS   = 200,
    parameter int CHAR_GAP_MS  = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic [4:0] morse_code,
    output logic [2:0] morse_len,
    output logic       char_valid,
    output logic       char_error,
    output logic       key_active
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_t;

    state_t        state;
    logic          key_s1;
    logic          key_s2;
    logic          key_d;
    logic          rise;
    logic          fall;
    logic [PW-1:0] presc;
    logic          ms_tick;
    logic [15:0]   ms_cnt;
    logic [15:0]   cnt_now;
    logic [4:0]    shreg;
    logic [2:0]    len;
    logic          ovf;
    logic          is_dash;
    logic          gap_done;

    assign key_active = key_s2;
    assign rise       = key_s2 & ~key_d;
    assign fall       = ~key_s2 & key_d;
    assign ms_tick    = (presc == PW'(CLK_PER_MS - 1));

    // Count including the tick of this cycle, so a fall lands on whole ms
    assign cnt_now  = (ms_tick && ms_cnt != 16'hFFFF) ? ms_cnt + 16'd1 : ms_cnt;
    assign is_dash  = (cnt_now >= 16'(DOT_MAX_MS));
    assign gap_done = ms_tick && (cnt_now == 16'(CHAR_GAP_MS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            key_d  <= 1'b0;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (rise || fall || ms_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ms_cnt     <= '0;
            shreg      <= '0;
            len        <= '0;
            ovf        <= 1'b0;
            morse_code <= '0;
            morse_len  <= '0;
            char_valid <= 1'b0;
            char_error <= 1'b0;
        end else begin
            char_valid <= 1'b0;
            char_error <= 1'b0;
            ms_cnt     <= cnt_now;
            unique case (state)
                IDLE: begin
                    ms_cnt <= '0;
                    if (rise) begin
                        state <= PRESS;
                    end
                end
                PRESS: begin
                    if (fall) begin
                        ms_cnt <= '0;
                        if (cnt_now < 16'(MIN_PRESS_MS)) begin
                            state <= (len != 3'd0) ? GAP : IDLE;
                        end else begin
                            state <= GAP;
                            if (len == 3'd5) begin
                                ovf <= 1'b1;
                            end else begin
                                shreg <= shreg | (5'(is_dash) << len);
                                len   <= len + 3'd1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (ovf) begin
                            char_error <= 1'b1;
                        end else begin
                            morse_code <= shreg;
                            morse_len  <= len;
                            char_valid <= 1'b1;
                        end
                        shreg  <= '0;
                        len    <= '0;
                        ovf    <= 1'b0;
                        ms_cnt <= '0;
                        state  <= rise ? PRESS : IDLE;
                    end else if (rise) begin
                        ms_cnt <= '0;
                        state  <= PRESS;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/morse_key_receiver.md
Name: morse_key_receiver

Overview:
- Timing-based Morse receiver for a single straight-key input. It is the receive end of the tone/keying protocol that buzzer_driver transmits.
- Measures key-down durations to classify dot or dash, and key-up durations to detect end of character.
- Emits a packed morse_code/morse_len pair with a one-cycle valid strobe, which feeds morse_decoder directly in Mode 1 as an alternative to separate dot/dash buttons.

Parameters:
- CLK_PER_MS, 1000: clk cycles per millisecond tick (1 MHz clk).
- MIN_PRESS_MS, 20: key-down shorter than this is a glitch and is discarded.
- DOT_MAX_MS, 200: key-down of MIN_PRESS_MS..DOT_MAX_MS-1 is a dot; DOT_MAX_MS or more is a dash.
- CHAR_GAP_MS, 600: key-up lasting this long ends the character.

Ports:
- clk, input, 1: system clock, 1 MHz.
- rst, input, 1: asynchronous reset, active-high.
- key_in, input, 1: debounced key level, 1 = pressed. Treated as asynchronous.
- morse_code, output, 5: received symbols; bit i = symbol i, first symbol in bit 0; 1 = dash, 0 = dot; unused bits 0.
- morse_len, output, 3: number of symbols, 1..5.
- char_valid, output, 1: one-clk pulse when morse_code/morse_len are updated.
- char_error, output, 1: one-clk pulse when a character exceeded 5 symbols.
- key_active, output, 1: synchronized key level, for LED/sidetone.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, symbol shift register/len/overflow flag cleared, counters 0. Reset mid-operation abandons the character; nothing is emitted afterwards for it.
- key_in passes through a 2-flop synchronizer. All edge detection uses the synchronized level, giving 2 clk latency (included in timing tolerances). key_active is the synchronized level.
- Prescaler counts 0..CLK_PER_MS-1 and issues ms_tick on wrap. It is cleared on every synchronized key edge, so durations are exact whole ms from the edge.
- ms_cnt is 16 bits, increments on ms_tick, saturates at 65535 and never wraps. It is cleared on every state entry.
- IDLE: no symbols held. Key rise goes to PRESS.
- PRESS: counts key-down ms. On key fall:
  - ms_cnt < MIN_PRESS_MS: glitch, no symbol. Go to GAP if len > 0, else IDLE. The gap timer restarts from this release.
  - ms_cnt < DOT_MAX_MS: append dot.
  - otherwise: append dash.
  - Append writes bit[len] and increments len. If len is already 5, the symbol is dropped and the overflow flag is set.
  - Go to GAP.
- GAP: counts key-up ms.
  - Key rise goes to PRESS.
  - When ms_cnt reaches CHAR_GAP_MS (evaluated on the ms_tick cycle):
    - no overflow: register shift register into morse_code and len into morse_len, and pulse char_valid in that same cycle;
    - overflow: pulse char_error only, leaving morse_code/morse_len unchanged;
    - in both cases clear the shift register, len and overflow flag, then go to IDLE.
  - A key rise in the same cycle as gap expiry: expiry wins. The character is emitted, then the FSM enters PRESS directly with the accumulator cleared.
- morse_code/morse_len hold their last emitted value until the next emission.
- char_valid and char_error are never asserted together. Each is high for exactly 1 clk.
- A long hold saturates ms_cnt and still classifies as a dash.

Test Plan:
All scenarios use CLK_PER_MS=10, with defaults otherwise; times below are in ms.
1. Letter A: press 100, release 100, press 300, release 800 -> exactly one char_valid, code=5'b00010, len=3'd2, pulse 600 ms (+2 clk) after last release.
2. Glitch immunity: press 80 (E), release 300, 10 ms pulse, release 700 -> single char_valid, code=0, len=1, pulse 600 ms after the glitch release.
3. Overflow: six 50 ms dots with 100 ms gaps, then idle 700 -> char_error pulse once, no char_valid, morse_code/morse_len keep the prior value.
4. Dot/dash boundary: press 199 -> dot (code=0, len=1); press 200 -> dash (code=1, len=1); press 19 alone -> no output.
5. Reset mid-character: press 100, release 100, press 50, assert rst during press -> all outputs 0 immediately; release and wait 1000 -> no char_valid.
6. Saturation plus back-to-back: hold 70000 (T: code=1, len=1, valid), then re-press exactly at gap expiry -> T emitted, next character starts cleanly (press 100, release 700 -> E: code=0, len=1).
